// File: rtl/adpll_tdc_pkg.sv
// Shared constants and the averaging-state type used by the TDC thermometer encoder.
package adpll_tdc_pkg;

    localparam int N_TAPS_DEF  = 64;
    localparam int AVG_LOG_MAX = 4;

    typedef enum logic {
        ACC  = 1'b0,
        DUMP = 1'b1
    } avg_state_t;

endpackage

// File: rtl/tdc_bubble_fix.sv
// Three-tap majority filter over a thermometer word, with a flag raised whenever any bit was changed.
module tdc_bubble_fix
    import adpll_tdc_pkg::*;
#(
    parameter int N_TAPS = N_TAPS_DEF
) (
    input  logic [N_TAPS-1:0] i_therm,
    output logic [N_TAPS-1:0] o_corr,
    output logic              o_bubble
);

    // Padded with a virtual one below tap 0 and a virtual zero above the last tap.
    logic [N_TAPS+1:0] w_ext;

    assign w_ext = {1'b0, i_therm, 1'b1};

    genvar gi;
    generate
        for (gi = 0; gi < N_TAPS; gi++) begin : g_maj
            assign o_corr[gi] = (w_ext[gi]   & w_ext[gi+1]) |
                                (w_ext[gi]   & w_ext[gi+2]) |
                                (w_ext[gi+1] & w_ext[gi+2]);
        end
    endgenerate

    assign o_bubble = |(o_corr ^ i_therm);

endmodule

// File: rtl/tdc_therm_encoder.sv
// TDC thermometer-to-binary encoder: two-flop capture, bubble fix, popcount tree,
// and an optional power-of-two averaging stage feeding the ADPLL loop filter.
module tdc_therm_encoder
    import adpll_tdc_pkg::*;
#(
    parameter int N_TAPS  = N_TAPS_DEF,
    parameter int AVG_LOG = 0,
    parameter int OUT_W   = $clog2(N_TAPS) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_TAPS-1:0] therm,
    input  logic              sample_en,
    input  logic              clear,
    output logic [OUT_W-1:0]  code,
    output logic              code_vld,
    output logic              bubble,
    output logic              sat
);

    localparam int LOG_N   = $clog2(N_TAPS);
    localparam int AVG_EFF = (AVG_LOG > AVG_LOG_MAX) ? AVG_LOG_MAX : AVG_LOG;
    localparam logic [OUT_W-1:0] FULL_CODE = OUT_W'(N_TAPS);

    logic [N_TAPS-1:0] r_sync1, r_sync2, r_corr;
    logic              r_v1, r_v2, r_v3, r_v4;
    logic              r_bub3, r_bub4, r_sat4;
    logic [OUT_W-1:0]  r_pos;

    logic [N_TAPS-1:0] w_corr;
    logic              w_bub;
    logic [OUT_W-1:0]  w_pos;

    logic [OUT_W-1:0]  r_code;
    logic              r_code_vld, r_bubble, r_sat;

    tdc_bubble_fix #(
        .N_TAPS (N_TAPS)
    ) u_bubble_fix (
        .i_therm  (r_sync2),
        .o_corr   (w_corr),
        .o_bubble (w_bub)
    );

    // Balanced adder tree over the corrected word; level gl holds N_TAPS>>gl partial sums of gl+1 bits.
    genvar gl, gi;
    generate
        for (gl = 1; gl <= LOG_N; gl++) begin : g_lvl
            logic [gl:0] w_sum [0:(N_TAPS>>gl)-1];
            for (gi = 0; gi < (N_TAPS >> gl); gi++) begin : g_node
                if (gl == 1) begin : g_leaf
                    assign w_sum[gi] = {1'b0, r_corr[2*gi]} + {1'b0, r_corr[2*gi+1]};
                end else begin : g_add
                    assign w_sum[gi] = {1'b0, g_lvl[gl-1].w_sum[2*gi]} +
                                       {1'b0, g_lvl[gl-1].w_sum[2*gi+1]};
                end
            end
        end
    endgenerate

    assign w_pos = OUT_W'(g_lvl[LOG_N].w_sum[0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_corr  <= '0;
            r_pos   <= '0;
            r_v1    <= 1'b0;
            r_v2    <= 1'b0;
            r_v3    <= 1'b0;
            r_v4    <= 1'b0;
            r_bub3  <= 1'b0;
            r_bub4  <= 1'b0;
            r_sat4  <= 1'b0;
        end else begin
            r_v1 <= sample_en;
            if (sample_en) begin
                r_sync1 <= therm;
            end
            r_v2    <= r_v1;
            r_sync2 <= r_sync1;
            r_v3    <= r_v2;
            r_corr  <= w_corr;
            r_bub3  <= w_bub;
            r_v4    <= r_v3;
            r_pos   <= w_pos;
            r_sat4  <= (w_pos == FULL_CODE);
            r_bub4  <= r_bub3;
        end
    end

    generate
        if (AVG_EFF == 0) begin : g_pass
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_code     <= '0;
                    r_code_vld <= 1'b0;
                    r_bubble   <= 1'b0;
                    r_sat      <= 1'b0;
                end else begin
                    r_code_vld <= r_v4 & ~clear;
                    if (r_v4 && !clear) begin
                        r_code   <= r_pos;
                        r_bubble <= r_bub4;
                        r_sat    <= r_sat4;
                    end
                end
            end
        end else begin : g_avg
            localparam int ACC_W = OUT_W + AVG_EFF;

            avg_state_t         r_state, w_state_next;
            logic [ACC_W-1:0]   r_acc, w_acc_next, w_sum;
            logic [AVG_EFF-1:0] r_cnt, w_cnt_next;
            logic               r_bub_sticky, w_bub_sticky_next;
            logic               r_sat_sticky, w_sat_sticky_next;
            logic               w_last, w_dump, w_bub_out, w_sat_out;

            assign w_sum     = r_acc + ACC_W'(r_pos);
            assign w_last    = r_v4 && (r_cnt == '1);
            assign w_bub_out = r_bub_sticky | r_bub4;
            assign w_sat_out = r_sat_sticky | r_sat4;

            always_comb begin
                w_state_next      = r_state;
                w_acc_next        = r_acc;
                w_cnt_next        = r_cnt;
                w_bub_sticky_next = r_bub_sticky;
                w_sat_sticky_next = r_sat_sticky;
                w_dump            = 1'b0;

                case (r_state)
                    ACC:     w_state_next = w_last ? DUMP : ACC;
                    DUMP:    w_state_next = ACC;
                    default: w_state_next = ACC;
                endcase

                // Clear wins over an arriving sample: that sample is dropped.
                if (clear) begin
                    w_state_next      = ACC;
                    w_acc_next        = '0;
                    w_cnt_next        = '0;
                    w_bub_sticky_next = 1'b0;
                    w_sat_sticky_next = 1'b0;
                end else if (r_v4) begin
                    if (w_last) begin
                        w_dump            = 1'b1;
                        w_acc_next        = '0;
                        w_cnt_next        = '0;
                        w_bub_sticky_next = 1'b0;
                        w_sat_sticky_next = 1'b0;
                    end else begin
                        w_acc_next        = w_sum;
                        w_cnt_next        = r_cnt + AVG_EFF'(1);
                        w_bub_sticky_next = w_bub_out;
                        w_sat_sticky_next = w_sat_out;
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_state      <= ACC;
                    r_acc        <= '0;
                    r_cnt        <= '0;
                    r_bub_sticky <= 1'b0;
                    r_sat_sticky <= 1'b0;
                    r_code       <= '0;
                    r_code_vld   <= 1'b0;
                    r_bubble     <= 1'b0;
                    r_sat        <= 1'b0;
                end else begin
                    r_state      <= w_state_next;
                    r_acc        <= w_acc_next;
                    r_cnt        <= w_cnt_next;
                    r_bub_sticky <= w_bub_sticky_next;
                    r_sat_sticky <= w_sat_sticky_next;
                    r_code_vld   <= w_dump;
                    if (w_dump) begin
                        r_code   <= w_sum[ACC_W-1:AVG_EFF];
                        r_bubble <= w_bub_out;
                        r_sat    <= w_sat_out;
                    end
                end
            end
        end
    endgenerate

    assign code     = r_code;
    assign code_vld = r_code_vld;
    assign bubble   = r_bubble;
    assign sat      = r_sat;

endmodule

// File: tb/tb_tdc_therm_encoder.sv
// Bench for tdc_therm_encoder: a pass-through and a 4-deep averaging instance share one stimulus stream
// and are compared every cycle against a sample-list model, plus directed checks of fixed values.
module tb_tdc_therm_encoder;

    localparam int N  = 64;
    localparam int OW = 7;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  therm;
    logic          sample_en;
    logic          clear;
    logic [OW-1:0] code0, code2;
    logic          vld0, vld2, bub0, bub2, sat0, sat2;

    always #5 clk = ~clk;

    tdc_therm_encoder #(.N_TAPS(N), .AVG_LOG(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .therm(therm), .sample_en(sample_en), .clear(clear),
        .code(code0), .code_vld(vld0), .bubble(bub0), .sat(sat0)
    );

    tdc_therm_encoder #(.N_TAPS(N), .AVG_LOG(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .therm(therm), .sample_en(sample_en), .clear(clear),
        .code(code2), .code_vld(vld2), .bubble(bub2), .sat(sat2)
    );

    typedef struct {
        int arrive;
        int pos;
        bit bub;
        bit sat;
    } smp_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   vld_seen = 0;
    smp_t inflight[$];
    smp_t window[$];
    int   strobes2[$];
    int   e_code0 = 0, e_code2 = 0;
    bit   e_vld0 = 0, e_vld2 = 0, e_bub0 = 0, e_bub2 = 0, e_sat0 = 0, e_sat2 = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] thermo(input int p);
        logic [N-1:0] one;
        one = 1;
        if (p >= N) return '1;
        return (one << p) - one;
    endfunction

    // Majority of each tap with its neighbours, then count the ones.
    function automatic smp_t ref_encode(input logic [N-1:0] t);
        smp_t s;
        int   l, r, c;
        s.arrive = 0;
        s.pos    = 0;
        s.bub    = 0;
        for (int i = 0; i < N; i++) begin
            l = (i == 0)     ? 1 : int'(t[i-1]);
            r = (i == N - 1) ? 0 : int'(t[i+1]);
            c = (l + int'(t[i]) + r >= 2) ? 1 : 0;
            s.pos += c;
            if (c != int'(t[i])) s.bub = 1;
        end
        s.sat = (s.pos == N);
        return s;
    endfunction

    task automatic tick();
        smp_t s;
        int   sum;
        bit   b, st;
        @(posedge clk);
        cyc++;
        e_vld0 = 0;
        e_vld2 = 0;
        if (!rst_n) begin
            inflight.delete();
            window.delete();
            e_code0 = 0; e_bub0 = 0; e_sat0 = 0;
            e_code2 = 0; e_bub2 = 0; e_sat2 = 0;
        end else begin
            if (inflight.size() > 0 && inflight[0].arrive == cyc) begin
                s = inflight.pop_front();
                if (!clear) begin
                    e_vld0 = 1; e_code0 = s.pos; e_bub0 = s.bub; e_sat0 = s.sat;
                    window.push_back(s);
                    if (window.size() == 4) begin
                        sum = 0; b = 0; st = 0;
                        foreach (window[i]) begin
                            sum += window[i].pos;
                            b   |= window[i].bub;
                            st  |= window[i].sat;
                        end
                        e_vld2 = 1; e_code2 = sum / 4; e_bub2 = b; e_sat2 = st;
                        window.delete();
                    end
                end
            end
            if (clear) window.delete();
            if (sample_en) begin
                s = ref_encode(therm);
                s.arrive = cyc + 4;
                inflight.push_back(s);
            end
        end
        #1;
        chk("m_vld0", vld0, e_vld0);
        chk("m_code0", code0, e_code0);
        chk("m_bub0", bub0, e_bub0);
        chk("m_sat0", sat0, e_sat0);
        chk("m_vld2", vld2, e_vld2);
        chk("m_code2", code2, e_code2);
        chk("m_bub2", bub2, e_bub2);
        chk("m_sat2", sat2, e_sat2);
        if (vld2) strobes2.push_back(cyc);
        if (vld0 || vld2) vld_seen++;
        if (vld0) $display("[TB] cyc=%0d avg_log=0 code=%0d bubble=%0d sat=%0d", cyc, code0, bub0, sat0);
        if (vld2) $display("[TB] cyc=%0d avg_log=2 code=%0d bubble=%0d sat=%0d", cyc, code2, bub2, sat2);
    endtask

    task automatic single(input string tag, input logic [N-1:0] t, input int ec, input bit eb, input bit es);
        therm = t;
        sample_en = 1;
        tick();
        sample_en = 0;
        repeat (3) tick();
        chk({tag, "_early"}, vld0, 0);
        tick();
        chk({tag, "_vld"}, vld0, 1);
        chk({tag, "_code"}, code0, ec);
        chk({tag, "_bubble"}, bub0, eb);
        chk({tag, "_sat"}, sat0, es);
    endtask

    initial begin
        rst_n = 0; therm = '0; sample_en = 0; clear = 0;
        repeat (3) tick();
        chk("rst_code0", code0, 0);
        chk("rst_vld0", vld0, 0);
        chk("rst_code2", code2, 0);
        chk("rst_vld2", vld2, 0);
        rst_n = 1;
        tick();

        // Single samples through the pass-through instance; the averager sees the same four.
        single("t16", 64'h0000_0000_0000_FFFF, 16, 0, 0);
        single("bub16", 64'h0000_0000_0000_FF7F, 16, 1, 0);
        single("ones", '1, 64, 0, 1);
        single("zeros", '0, 0, 0, 0);
        chk("mix_vld2", vld2, 1);
        chk("mix_code2", code2, 24);
        chk("mix_bub2", bub2, 1);
        chk("mix_sat2", sat2, 1);

        // Back-to-back 10..13 averages to 11.
        clear = 1; tick(); clear = 0;
        for (int p = 10; p <= 13; p++) begin
            therm = thermo(p); sample_en = 1; tick();
        end
        sample_en = 0;
        repeat (3) tick();
        chk("avg_early", vld2, 0);
        tick();
        chk("avg_vld", vld2, 1);
        chk("avg_code", code2, 11);

        // Continuous sampling: strobes every 4 cycles.
        clear = 1; tick(); clear = 0;
        strobes2.delete();
        sample_en = 1;
        for (int k = 0; k < 12; k++) begin
            therm = thermo(int'($urandom_range(0, 64)));
            tick();
        end
        sample_en = 0;
        repeat (6) tick();
        chk("strobe_count", strobes2.size(), 3);
        for (int i = 1; i < strobes2.size(); i++) chk("strobe_gap", strobes2[i] - strobes2[i-1], 4);

        // Clear after two samples: only the following four count.
        therm = thermo(5); sample_en = 1;
        repeat (2) tick();
        sample_en = 0;
        repeat (4) tick();
        clear = 1; tick(); clear = 0;
        therm = thermo(20); sample_en = 1;
        repeat (4) tick();
        sample_en = 0;
        repeat (3) tick();
        chk("clr_early", vld2, 0);
        tick();
        chk("clr_vld", vld2, 1);
        chk("clr_code", code2, 20);

        // A sample reaching the output on a clear edge is dropped; outputs hold.
        therm = thermo(30); sample_en = 1; tick(); sample_en = 0;
        repeat (3) tick();
        clear = 1; tick(); clear = 0;
        chk("drop_vld0", vld0, 0);
        chk("drop_code0", code0, 20);

        // Reset with three samples in flight.
        for (int p = 7; p <= 9; p++) begin
            therm = thermo(p); sample_en = 1; tick();
        end
        sample_en = 0;
        rst_n = 0;
        #1;
        chk("rst_mid_code0", code0, 0);
        chk("rst_mid_code2", code2, 0);
        chk("rst_mid_vld0", vld0, 0);
        tick();
        rst_n = 1;
        vld_seen = 0;
        repeat (8) tick();
        chk("rst_no_vld", vld_seen, 0);
        chk("rst_after_code0", code0, 0);
        chk("rst_after_bub0", bub0, 0);

        // Randomised traffic with gaps, bubbles, garbage words and occasional clears.
        for (int k = 0; k < 400; k++) begin
            sample_en = ($urandom_range(0, 3) != 0);
            clear     = ($urandom_range(0, 29) == 0);
            case ($urandom_range(0, 3))
                0, 1: therm = thermo(int'($urandom_range(0, 64)));
                2: begin
                    therm = thermo(int'($urandom_range(0, 64)));
                    therm[$urandom_range(0, 63)] = ~therm[$urandom_range(0, 63)];
                end
                default: therm = {$urandom, $urandom};
            endcase
            tick();
        end
        sample_en = 0;
        clear = 0;
        repeat (8) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
